mux_scan_n: RTL and testbench

//   Parametrised N-channel, WIDTH-bit registered multiplexer.
//   - Manual mode: channel chosen by a load strobe.
//   - Scan mode: channels rotate automatically, DWELL cycles each.
//   - Every channel change is preceded by a BLANK-cycle hold, so no mixed-channel data reaches dout.

---
 rtl/mux_scan_n_pkg.sv | 21 ++
 rtl/mux_scan_n_if.sv | 26 ++
 rtl/mux_dwell_cnt.sv | 33 +++
 rtl/mux_scan_n.sv | 112 +++++++++++
 tb/tb_mux_scan_n.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mux_scan_n_pkg.sv
// Shared definitions for the scanning multiplexer: FSM encodings and
// elaboration-time width helpers.
package mux_scan_n_pkg;

   localparam logic [0:0] ST_PASS  = 1'b0;
   localparam logic [0:0] ST_BLANK = 1'b1;

   // Smallest w with 2**w >= n.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

   // Bits needed to hold max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Channel bus of the scanning multiplexer: packed channel data, selection
// controls and the registered output/status signals.
interface mux_scan_n_if #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CH    = 4,
   parameter int unsigned SELW  = 2
);
   logic [CH*WIDTH-1:0] din;
   logic                mode;
   logic [SELW-1:0]     sel_in;
   logic                sel_load;
   logic [WIDTH-1:0]    dout;
   logic [SELW-1:0]     sel_cur;
   logic                sw;
   logic                err;

   modport master (
      output din, mode, sel_in, sel_load,
      input  dout, sel_cur, sw, err
   );

   modport slave (
      input  din, mode, sel_in, sel_load,
      output dout, sel_cur, sw, err
   );
endinterface

// File: rtl/mux_dwell_cnt.sv
// Terminal-count counter: counts 0..MAX while enabled, wraps after MAX,
// clr has priority over en; tc flags the MAX count.
module mux_dwell_cnt #(
   parameter int unsigned MAX = 7,
   parameter int unsigned W   = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);
   localparam logic [W-1:0] MAX_C = W'(MAX);
   localparam logic [W-1:0] ONE_C = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tc_o = (cnt_q == MAX_C);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = tc_o ? '0 : cnt_q + ONE_C;
   end

   // NOTE: state registers use non-blocking assignment so every flop samples
   // pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered selector with manual and scan modes; every channel
// change passes through a BLANK hold so dout never mixes channels.
module mux_scan_n
   import mux_scan_n_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CH    = 4,
   parameter int unsigned SELW  = 2,
   parameter int unsigned DWELL = 8,
   parameter int unsigned BLANK = 2
) (
   input  logic        clk,
   input  logic        rst,
   mux_scan_n_if.slave bus
);
   localparam int unsigned DW_W = cnt_width(int'(DWELL) - 1);
   localparam int unsigned BL_W = cnt_width(int'(BLANK) - 1);
   localparam logic [SELW-1:0] SEL_ONE = SELW'(1);

   logic [0:0]       state_q, state_d;
   logic [SELW-1:0]  sel_cur_q, sel_cur_d;
   logic [SELW-1:0]  tgt_q, tgt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             sw_q, sw_d;
   logic             err_q, err_d;

   logic            sel_oor, load_ok, blank_restart;
   logic            dwell_tc, blank_tc;
   logic [SELW-1:0] next_sel;

   // Range check is done in 32 bits so CH == 2**SELW cannot wrap to zero.
   assign sel_oor  = (32'(bus.sel_in) >= CH);
   assign load_ok  = bus.sel_load && !sel_oor && !bus.mode;
   assign next_sel = (32'(sel_cur_q) == CH - 1) ? '0 : sel_cur_q + SEL_ONE;

   mux_dwell_cnt #(.MAX(DWELL - 1), .W(DW_W)) u_dwell (
      .clk   (clk),
      .rst   (rst),
      .clr_i ((state_q != ST_PASS) || !bus.mode),
      .en_i  ((state_q == ST_PASS) && bus.mode),
      .tc_o  (dwell_tc)
   );

   mux_dwell_cnt #(.MAX(BLANK - 1), .W(BL_W)) u_blank (
      .clk   (clk),
      .rst   (rst),
      .clr_i ((state_q == ST_PASS) || blank_restart),
      .en_i  (state_q == ST_BLANK),
      .tc_o  (blank_tc)
   );

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d       = state_q;
      sel_cur_d     = sel_cur_q;
      tgt_d         = tgt_q;
      dout_d        = dout_q;
      sw_d          = 1'b0;
      err_d         = bus.sel_load && sel_oor;
      blank_restart = 1'b0;
      case (state_q)
         ST_PASS: begin
            dout_d = bus.din[32'(sel_cur_q) * WIDTH +: WIDTH];
            if (bus.mode) begin
               if (dwell_tc) begin
                  tgt_d   = next_sel;
                  state_d = ST_BLANK;
               end
            end else if (load_ok && (bus.sel_in != sel_cur_q)) begin
               tgt_d   = bus.sel_in;
               state_d = ST_BLANK;
            end
         end
         default: begin
            // A fresh manual load retargets and restarts the hold, even when
            // it names the channel already on dout.
            if (load_ok) begin
               tgt_d         = bus.sel_in;
               blank_restart = 1'b1;
            end else if (blank_tc) begin
               sel_cur_d = tgt_q;
               state_d   = ST_PASS;
               sw_d      = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_PASS;
         sel_cur_q <= '0;
         tgt_q     <= '0;
         dout_q    <= '0;
         sw_q      <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_cur_q <= sel_cur_d;
         tgt_q     <= tgt_d;
         dout_q    <= dout_d;
         sw_q      <= sw_d;
         err_q     <= err_d;
      end
   end

   assign bus.dout    = dout_q;
   assign bus.sel_cur = sel_cur_q;
   assign bus.sw      = sw_q;
   assign bus.err     = err_q;
endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench: instance A is the default 4-channel build, instance B a
// 3-channel build with short dwell/blank for range and scan-wrap vectors.
module tb_mux_scan_n;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   sw_cnt;

   always #5 clk = ~clk;

   mux_scan_n_if #(.WIDTH(4), .CH(4), .SELW(2)) ifa ();
   mux_scan_n_if #(.WIDTH(4), .CH(3), .SELW(2)) ifb ();

   mux_scan_n #(.WIDTH(4), .CH(4), .SELW(2), .DWELL(8), .BLANK(2)) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (ifa.slave)
   );

   mux_scan_n #(.WIDTH(4), .CH(3), .SELW(2), .DWELL(4), .BLANK(1)) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (ifb.slave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      rst_a = 1'b1;  rst_b = 1'b1;
      ifa.din = 16'h4321; ifa.mode = 1'b0; ifa.sel_in = '0; ifa.sel_load = 1'b0;
      ifb.din = 12'h321;  ifb.mode = 1'b0; ifb.sel_in = '0; ifb.sel_load = 1'b0;

      // 1. Reset held three cycles, then one cycle to first data.
      cyc(3);
      check("rst_dout",    ifa.dout,    0);
      check("rst_sel_cur", ifa.sel_cur, 0);
      check("rst_sw",      ifa.sw,      0);
      check("rst_err",     ifa.err,     0);
      rst_a = 1'b0; rst_b = 1'b0;
      cyc(1);
      check("rel_dout_a", ifa.dout, 4'h1);
      check("rel_dout_b", ifb.dout, 4'h1);

      // 2. Manual change to channel 2.
      ifa.sel_in = 2'd2; ifa.sel_load = 1'b1;
      cyc(1); ifa.sel_load = 1'b0;
      check("man_hold1_dout", ifa.dout, 4'h1);
      check("man_hold1_sw",   ifa.sw,   0);
      cyc(1);
      check("man_hold2_dout", ifa.dout,    4'h1);
      check("man_hold2_sel",  ifa.sel_cur, 0);
      cyc(1);
      check("man_sw",      ifa.sw,      1);
      check("man_sel_cur", ifa.sel_cur, 2);
      check("man_sw_dout", ifa.dout,    4'h1);
      cyc(1);
      check("man_new_dout", ifa.dout, 4'h3);
      check("man_sw_off",   ifa.sw,   0);

      // Loading the current channel does nothing.
      ifa.sel_in = 2'd2; ifa.sel_load = 1'b1;
      cyc(1); ifa.sel_load = 1'b0;
      sw_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (ifa.sw) sw_cnt++;
         cyc(1);
      end
      check("same_sel_no_sw", sw_cnt,       0);
      check("same_sel_cur",   ifa.sel_cur,  2);

      // 5. Retarget during BLANK: load 1 then load 3 a cycle later.
      ifa.sel_in = 2'd1; ifa.sel_load = 1'b1;
      cyc(1);
      check("rt_sw0", ifa.sw, 0);
      ifa.sel_in = 2'd3; ifa.sel_load = 1'b1;
      cyc(1); ifa.sel_load = 1'b0;
      check("rt_sw1", ifa.sw, 0);
      cyc(1);
      check("rt_sw2",  ifa.sw,      0);
      check("rt_sel2", ifa.sel_cur, 2);
      cyc(1);
      check("rt_sw3",  ifa.sw,      1);
      check("rt_sel3", ifa.sel_cur, 3);
      cyc(1);
      check("rt_dout", ifa.dout, 4'h4);
      check("rt_sw4",  ifa.sw,   0);

      // 6. Reset during BLANK aborts the change.
      ifa.sel_in = 2'd1; ifa.sel_load = 1'b1;
      cyc(1); ifa.sel_load = 1'b0;
      rst_a = 1'b1;
      cyc(1); rst_a = 1'b0;
      check("rb_dout_rst", ifa.dout, 0);
      sw_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         if (ifa.sw) sw_cnt++;
      end
      check("rb_no_sw",   sw_cnt,      0);
      check("rb_sel_cur", ifa.sel_cur, 0);
      check("rb_dout",    ifa.dout,    4'h1);

      // 3. Out-of-range load on the 3-channel build.
      ifb.sel_in = 2'd3; ifb.sel_load = 1'b1;
      cyc(1); ifb.sel_load = 1'b0;
      check("err_pulse",   ifb.err,     1);
      check("err_sel_cur", ifb.sel_cur, 0);
      check("err_dout",    ifb.dout,    4'h1);
      cyc(1);
      check("err_clear", ifb.err, 0);
      sw_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         if (ifb.sw) sw_cnt++;
      end
      check("err_no_sw",  sw_cnt,      0);
      check("err_sel_hd", ifb.sel_cur, 0);

      // 4. Scan wrap: DWELL=4, BLANK=1 -> change every 5 cycles, 0,1,2,0.
      ifb.mode = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         cyc(1);
         check($sformatf("scan_sw_%0d", i),  ifb.sw,      (i % 5 == 0) ? 1 : 0);
         check($sformatf("scan_sel_%0d", i), ifb.sel_cur, (i / 5) % 3);
         if (i == 6)  check("scan_dout_ch1", ifb.dout, 4'h2);
         if (i == 11) check("scan_dout_ch2", ifb.dout, 4'h3);
      end
      // sel_load ignored in scan mode but range is still checked.
      ifb.sel_in = 2'd3; ifb.sel_load = 1'b1;
      cyc(1); ifb.sel_load = 1'b0;
      check("scan_err", ifb.err, 1);
      // Leaving scan mode freezes the selection.
      ifb.mode = 1'b0;
      sw_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         cyc(1);
         if (ifb.sw) sw_cnt++;
      end
      check("stop_no_sw",   sw_cnt,      0);
      check("stop_sel_cur", ifb.sel_cur, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
